// File: rtl/if_fetch_unit.sv
// 3-wide instruction fetch stage: holds the PC, issues three consecutive word addresses,
// and registers the contiguous valid prefix of the returned instructions for decode.
module if_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  take_branch,
    input  logic [XLEN-1:0]       branch_target,
    input  logic                  id_stall,
    input  logic [2:0][31:0]      Icache_data_out,
    input  logic [2:0]            Icache_valid_out,
    output logic [2:0][XLEN-1:0]  proc2Icache_addr,
    output logic [1:0]            shift,
    output logic [2:0][31:0]      if_inst_out,
    output logic [2:0][XLEN-1:0]  if_pc_out,
    output logic [2:0]            if_valid_out
);

    logic [XLEN-1:0] pc;
    logic [1:0]      count;
    logic [2:0]      prefix;
    logic            accept;

    // Slot 2 is the oldest, so the valid prefix grows from slot 2 downwards.
    always_comb begin
        count = 2'd0;
        if (!Icache_valid_out[2])      count = 2'd0;
        else if (!Icache_valid_out[1]) count = 2'd1;
        else if (!Icache_valid_out[0]) count = 2'd2;
        else                           count = 2'd3;
    end

    assign prefix = {count != 2'd0, count[1], count == 2'd3};
    assign accept = !id_stall && !take_branch;

    // A full window reports 0: PC+12 lies outside what the controller tracks.
    assign shift = (reset && accept && count != 2'd3) ? count : 2'd0;

    assign proc2Icache_addr[2] = pc;
    assign proc2Icache_addr[1] = pc + XLEN'(4);
    assign proc2Icache_addr[0] = pc + XLEN'(8);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc           <= RESET_PC;
            if_inst_out  <= '0;
            if_pc_out    <= '0;
            if_valid_out <= '0;
        end else if (take_branch) begin
            pc           <= {branch_target[XLEN-1:2], 2'b00};
            if_valid_out <= '0;
        end else if (!id_stall) begin
            pc           <= pc + XLEN'({count, 2'b00});
            if_inst_out  <= Icache_data_out;
            if_pc_out    <= proc2Icache_addr;
            if_valid_out <= prefix;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a zero-latency cache returning addr ^ A5A5_0000.
module tb_if_fetch_unit;

    logic             clock = 1'b0;
    logic             reset;
    logic             take_branch;
    logic [31:0]      branch_target;
    logic             id_stall;
    logic [2:0][31:0] Icache_data_out;
    logic [2:0]       Icache_valid_out;
    logic [2:0][31:0] proc2Icache_addr;
    logic [1:0]       shift;
    logic [2:0][31:0] if_inst_out;
    logic [2:0][31:0] if_pc_out;
    logic [2:0]       if_valid_out;

    int checks = 0;
    int errors = 0;

    if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clock            (clock),
        .reset            (reset),
        .take_branch      (take_branch),
        .branch_target    (branch_target),
        .id_stall         (id_stall),
        .Icache_data_out  (Icache_data_out),
        .Icache_valid_out (Icache_valid_out),
        .proc2Icache_addr (proc2Icache_addr),
        .shift            (shift),
        .if_inst_out      (if_inst_out),
        .if_pc_out        (if_pc_out),
        .if_valid_out     (if_valid_out)
    );

    always #5 clock = ~clock;

    assign Icache_data_out[2] = proc2Icache_addr[2] ^ 32'hA5A5_0000;
    assign Icache_data_out[1] = proc2Icache_addr[1] ^ 32'hA5A5_0000;
    assign Icache_data_out[0] = proc2Icache_addr[0] ^ 32'hA5A5_0000;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input logic st, input logic br, input logic [31:0] tgt);
        Icache_valid_out = v;
        id_stall         = st;
        take_branch      = br;
        branch_target    = tgt;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(3'b110, 1'b0, 1'b0, 32'h0);
        check("rst_addr",  proc2Icache_addr, {32'h0, 32'h4, 32'h8});
        check("rst_shift", shift, 2'd0);
        check("rst_valid", if_valid_out, 3'b000);
        check("rst_pc",    if_pc_out, 96'h0);
        check("rst_inst",  if_inst_out, 96'h0);

        // Full packet from RESET_PC.
        drive(3'b111, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("full_shift", shift, 2'd0);
        tick();
        check("full_valid", if_valid_out, 3'b111);
        check("full_pc",    if_pc_out, {32'h0, 32'h4, 32'h8});
        check("full_inst",  if_inst_out, {32'hA5A5_0000, 32'hA5A5_0004, 32'hA5A5_0008});
        check("full_addr",  proc2Icache_addr, {32'hC, 32'h10, 32'h14});

        // Two-slot prefix at 0x100.
        drive(3'b000, 1'b0, 1'b1, 32'h100);
        tick();
        drive(3'b110, 1'b0, 1'b0, 32'h0);
        check("p2_shift", shift, 2'd2);
        tick();
        check("p2_valid", if_valid_out, 3'b110);
        check("p2_pc2",   if_pc_out[2], 32'h100);
        check("p2_addr",  proc2Icache_addr, {32'h108, 32'h10C, 32'h110});

        // Leading miss at 0x40 retries, then a single hit.
        drive(3'b000, 1'b0, 1'b1, 32'h40);
        tick();
        drive(3'b011, 1'b0, 1'b0, 32'h0);
        check("miss_shift", shift, 2'd0);
        tick();
        check("miss_valid", if_valid_out, 3'b000);
        check("miss_addr",  proc2Icache_addr, {32'h40, 32'h44, 32'h48});
        drive(3'b100, 1'b0, 1'b0, 32'h0);
        check("one_shift", shift, 2'd1);
        tick();
        check("one_valid", if_valid_out, 3'b100);
        check("one_pc",    if_pc_out, {32'h40, 32'h44, 32'h48});
        check("one_inst2", if_inst_out[2], 32'hA5A5_0040);
        check("one_addr",  proc2Icache_addr, {32'h44, 32'h48, 32'h4C});

        // Stall holds PC and packet.
        drive(3'b111, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("stall_shift", shift, 2'd0);
            tick();
            check("stall_valid", if_valid_out, 3'b100);
            check("stall_pc",    if_pc_out, {32'h40, 32'h44, 32'h48});
            check("stall_addr",  proc2Icache_addr, {32'h44, 32'h48, 32'h4C});
        end

        // Branch beats stall and aligns the target.
        drive(3'b111, 1'b1, 1'b1, 32'h203);
        check("br_shift", shift, 2'd0);
        tick();
        check("br_valid", if_valid_out, 3'b000);
        check("br_addr",  proc2Icache_addr, {32'h200, 32'h204, 32'h208});

        // Address wrap near the top of memory.
        drive(3'b000, 1'b0, 1'b1, 32'hFFFF_FFF8);
        tick();
        drive(3'b111, 1'b0, 1'b0, 32'h0);
        check("wrap_addr",  proc2Icache_addr, {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0});
        check("wrap_shift", shift, 2'd0);
        tick();
        check("wrap_valid", if_valid_out, 3'b111);
        check("wrap_pc",    if_pc_out, {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0});
        check("wrap_next",  proc2Icache_addr, {32'h4, 32'h8, 32'hC});

        // Asynchronous reset mid-cycle.
        drive(3'b110, 1'b0, 1'b0, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", if_valid_out, 3'b000);
        check("arst_pc",    if_pc_out, 96'h0);
        check("arst_inst",  if_inst_out, 96'h0);
        check("arst_addr",  proc2Icache_addr, {32'h0, 32'h4, 32'h8});
        check("arst_shift", shift, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- 3-wide instruction fetch stage directly upstream of the instruction cache controller.
- Holds the PC and drives three consecutive word addresses to the cache controller.
- Collects the contiguous valid prefix of the returned instructions into a registered 3-slot packet for decode.
- Reports how far the fetch window advanced (shift) so the controller can track its miss address, and redirects on branch.

Parameters:
- XLEN, 32, address/PC width.
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- take_branch  in  1  redirect request, 1-cycle pulse.
- branch_target  in  XLEN  redirect PC; bits [1:0] forced to 0 internally.
- id_stall  in  1  decode cannot accept a new packet this cycle.
- Icache_data_out  in  3x32  instruction per slot; slot 2 is the oldest.
- Icache_valid_out  in  3  per-slot hit.
- proc2Icache_addr  out  3xXLEN  slot2=PC, slot1=PC+4, slot0=PC+8 (mod 2^XLEN).
- shift  out  2  instructions consumed this cycle, encoded as follows.
- if_inst_out  out  3x32  registered instruction packet.
- if_pc_out  out  3xXLEN  registered PC per slot.
- if_valid_out  out  3  registered slot valids, always a contiguous prefix from slot 2.

Behaviour:
- Async reset (reset=0):
  - PC=RESET_PC.
  - if_valid_out=0, if_inst_out=0, if_pc_out=0.
  - proc2Icache_addr reflects RESET_PC immediately.
  - shift=0.
- Addresses are combinational from the PC register. Cache data/valid are returned in the same cycle; zero-latency lookup.
- count (combinational) = length of the valid prefix:
  - 3 if valid=111;
  - 2 if valid=11x with slot0=0;
  - 1 if valid=10x;
  - 0 if valid[2]=0.
  - Valids after the first invalid slot are ignored.
- accept = !id_stall && !take_branch.
- shift = accept ? (count==3 ? 0 : count) : 0. This encoding is fixed by the controller interface: 3 maps to 0, because PC+12 is outside the window.
- Priority order at the clock edge:
  1. take_branch=1: PC<=branch_target&~3; if_valid_out<=000. This flushes the packet regardless of id_stall, and the packet is discarded.
  2. id_stall=1: PC and all output registers hold.
  3. Otherwise:
     - PC<=PC+4*count, wrapping mod 2^XLEN.
     - Slot k is loaded with its Icache data and address, and marked valid, if it lies in the prefix; remaining slots get valid=0.
     - If count=0, if_valid_out<=000 and PC holds; a retry happens each cycle.
- No internal FSM beyond the PC and packet registers. An outstanding miss is tracked only via shift/addresses to the controller.
- Stall with a pending miss: PC holds and addresses stay stable, so the controller keeps its request.
- PC wrap: PC=FFFF_FFF8 gives addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset deasserted mid-stream: the first edge after release behaves as a normal cycle from RESET_PC.

Test Plan:
- Reset with RESET_PC=0, all valids=111, id_stall=0 -> addrs 0/4/8; next edge: if_valid_out=111, if_pc_out=0/4/8, PC=12, shift=0.
- valid=110 at PC=0x100 -> shift=2; next: if_valid_out=110, PC=0x108, addrs 0x108/0x10C/0x110.
- valid=011 at PC=0x40 -> count=0, shift=0; next: if_valid_out=000, PC holds 0x40; then valid=100 -> PC=0x44, if_valid_out=100.
- id_stall=1 with a valid packet held -> outputs and PC unchanged over 5 cycles; shift=0 throughout.
- take_branch=1, branch_target=0x203, together with id_stall=1 -> next: if_valid_out=000, PC=0x200, addrs 0x200/0x204/0x208.
- PC=FFFF_FFF8, valid=111 -> addrs wrap (slot0 = 0); next PC=0000_0004. Assert reset=0 mid-packet -> outputs clear immediately, without waiting for a clock edge.
